// File: rtl/psram_wb_rdcache_if.sv
// Bus bundle for the PSRAM read cache: upstream Wishbone slave side, downstream
// Wishbone master side, flush strobe and hit/miss counters.
interface psram_wb_rdcache_if;
    logic [31:0] s_adr_i;
    logic [31:0] s_dat_i;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_i;
    logic        s_cyc_i;
    logic        s_stb_i;
    logic        s_we_i;
    logic        s_ack_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic        m_ack_i;
    logic        flush_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    // the cache itself
    modport slave (
        input  s_adr_i, s_dat_i, s_sel_i, s_cyc_i, s_stb_i, s_we_i,
        input  m_dat_i, m_ack_i, flush_i,
        output s_dat_o, s_ack_o,
        output m_adr_o, m_dat_o, m_sel_o, m_cyc_o, m_stb_o, m_we_o,
        output hit_cnt_o, miss_cnt_o
    );

    // requester plus downstream controller, seen from outside the cache
    modport master (
        output s_adr_i, s_dat_i, s_sel_i, s_cyc_i, s_stb_i, s_we_i,
        output m_dat_i, m_ack_i, flush_i,
        input  s_dat_o, s_ack_o,
        input  m_adr_o, m_dat_o, m_sel_o, m_cyc_o, m_stb_o, m_we_o,
        input  hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/psram_wb_rdcache.sv
// Direct-mapped write-through word read cache in front of the PSRAM Wishbone
// controller. Hits answer in one cycle; misses fetch one word; writes pass through.
module psram_wb_rdcache #(
    parameter int ENTRIES = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    psram_wb_rdcache_if.slave  bus
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 22 - IDX;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]         state;
    logic [ENTRIES-1:0] valid;
    logic [TAGW-1:0]    tag_mem  [ENTRIES];
    logic [31:0]        data_mem [ENTRIES];
    logic               fill_flushed;

    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] tag;
    logic            req;
    logic            hit;

    assign idx = bus.s_adr_i[IDX+1:2];
    assign tag = bus.s_adr_i[23:IDX+2];
    assign req = bus.s_cyc_i & bus.s_stb_i;
    assign hit = valid[idx] && (tag_mem[idx] == tag);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bus.s_ack_o    <= 1'b0;
            bus.s_dat_o    <= '0;
            bus.m_adr_o    <= '0;
            bus.m_dat_o    <= '0;
            bus.m_sel_o    <= '0;
            bus.m_cyc_o    <= 1'b0;
            bus.m_stb_o    <= 1'b0;
            bus.m_we_o     <= 1'b0;
            bus.hit_cnt_o  <= '0;
            bus.miss_cnt_o <= '0;
        end else begin
            bus.s_ack_o <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    if (bus.s_we_i) begin
                        bus.m_adr_o <= {8'h0, bus.s_adr_i[23:0]};
                        bus.m_dat_o <= bus.s_dat_i;
                        bus.m_sel_o <= bus.s_sel_i;
                        bus.m_we_o  <= 1'b1;
                        bus.m_cyc_o <= 1'b1;
                        bus.m_stb_o <= 1'b1;
                        state       <= WRITE;
                    end else if (hit) begin
                        bus.s_dat_o   <= data_mem[idx];
                        bus.s_ack_o   <= 1'b1;
                        bus.hit_cnt_o <= bus.hit_cnt_o + 16'd1;
                        state         <= RESP;
                    end else begin
                        bus.m_adr_o    <= {8'h0, bus.s_adr_i[23:2], 2'b00};
                        bus.m_sel_o    <= 4'hF;
                        bus.m_we_o     <= 1'b0;
                        bus.m_cyc_o    <= 1'b1;
                        bus.m_stb_o    <= 1'b1;
                        bus.miss_cnt_o <= bus.miss_cnt_o + 16'd1;
                        state          <= FILL;
                    end
                end
                FILL: if (bus.m_ack_i) begin
                    bus.m_cyc_o <= 1'b0;
                    bus.m_stb_o <= 1'b0;
                    bus.s_dat_o <= bus.m_dat_i;
                    bus.s_ack_o <= 1'b1;
                    state       <= RESP;
                end
                WRITE: if (bus.m_ack_i) begin
                    bus.m_cyc_o <= 1'b0;
                    bus.m_stb_o <= 1'b0;
                    bus.m_we_o  <= 1'b0;
                    bus.s_ack_o <= 1'b1;
                    state       <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flush seen at any point of a fill must keep the filled entry invalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid        <= '0;
            fill_flushed <= 1'b0;
        end else begin
            fill_flushed <= (state == FILL) && (fill_flushed || bus.flush_i);
            if (bus.flush_i)
                valid <= '0;
            else if (state == FILL && bus.m_ack_i && !fill_flushed)
                valid[idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (state == FILL && bus.m_ack_i) begin
            data_mem[idx] <= bus.m_dat_i;
            tag_mem[idx]  <= tag;
        end else if (state == WRITE && bus.m_ack_i && hit) begin
            for (int b = 0; b < 4; b++)
                if (bus.s_sel_i[b])
                    data_mem[idx][8*b +: 8] <= bus.s_dat_i[8*b +: 8];
        end
    end
endmodule
